// File: rtl/comp_minmax_pipe_if.sv
// Stream interface for the min/max reducer: the beat input side and the result output side.
// The master modport is the environment's view and the slave modport is the reducer's view.
interface comp_minmax_pipe_if #(
    parameter int LANES = 16,
    parameter int D     = 8
);
    localparam int IW  = LANES * D;
    localparam int IXW = $clog2(LANES);

    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  data_in;
    logic           mode_in;
    logic           out_valid;
    logic           out_ready;
    logic [D-1:0]   data_out;
    logic [IXW-1:0] idx_out;
    logic           mode_out;

    modport master (
        output in_valid, data_in, mode_in, out_ready,
        input  in_ready, out_valid, data_out, idx_out, mode_out
    );

    modport slave (
        input  in_valid, data_in, mode_in, out_ready,
        output in_ready, out_valid, data_out, idx_out, mode_out
    );
endinterface

// File: rtl/comp_minmax_pipe.sv
// Streaming min/max reducer. Each beat carries LANES chunks of D bits; a binary tree
// with one register level per tree level reports the extreme chunk and its lane index.
// Tree nodes are numbered level by level: level s occupies nodes
// off(s) .. off(s) + (LANES>>(s+1)) - 1, so the root is node LANES-2.
// The whole pipe advances together whenever the output register is free or being drained.
module comp_minmax_pipe #(
    parameter int LANES  = 16,
    parameter int D      = 8,
    parameter int SIGNED = 0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    comp_minmax_pipe_if.slave bus
);
    localparam int IXW    = $clog2(LANES);
    localparam int STAGES = $clog2(LANES);
    localparam int NNODE  = LANES - 1;
    localparam int NMID   = (LANES > 2) ? LANES - 2 : 1;
    localparam int NMIDS  = (STAGES > 1) ? STAGES - 1 : 1;

    // First node of tree level s.
    function automatic int off(input int s);
        return LANES - (LANES >> s);
    endfunction

    // True when the higher-index operand b replaces a; ties keep a so the lowest lane wins.
    function automatic logic take_hi(input logic [D-1:0] a, input logic [D-1:0] b,
                                     input logic mx);
        logic lt, gt;
        if (SIGNED != 0) begin
            lt = $signed(b) < $signed(a);
            gt = $signed(b) > $signed(a);
        end else begin
            lt = b < a;
            gt = b > a;
        end
        return mx ? gt : lt;
    endfunction

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_mode;

    logic [D-1:0]   val_d [NNODE];
    logic [IXW-1:0] idx_d [NNODE];

    logic [D-1:0]   mid_val_q  [NMID];
    logic [IXW-1:0] mid_idx_q  [NMID];
    logic           mid_mode_q [NMIDS];

    logic [D-1:0]   out_val_q;
    logic [IXW-1:0] out_idx_q;
    logic           out_mode_q;

    assign adv          = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.data_out  = out_val_q;
    assign bus.idx_out   = out_idx_q;
    assign bus.mode_out  = out_mode_q;

    // Valid and mode presented to each tree level: the input port for level 0, else the level above.
    always_comb begin
        src_vld     = '0;
        src_mode    = '0;
        src_vld[0]  = bus.in_valid;
        src_mode[0] = bus.mode_in;
        for (int s = 1; s < STAGES; s++) begin
            src_vld[s]  = vld_q[s-1];
            src_mode[s] = mid_mode_q[s-1];
        end
    end

    // Pairwise compare at every tree node; (a, b) are the lower and higher index children.
    always_comb begin
        logic [D-1:0]   va, vb;
        logic [IXW-1:0] ia, ib;
        val_d = '{default: '0};
        idx_d = '{default: '0};
        va = '0;
        vb = '0;
        ia = '0;
        ib = '0;
        for (int s = 0; s < STAGES; s++) begin
            for (int j = 0; j < (LANES >> (s + 1)); j++) begin
                if (s == 0) begin
                    va = bus.data_in[2*j*D +: D];
                    vb = bus.data_in[(2*j+1)*D +: D];
                    ia = IXW'(2*j);
                    ib = IXW'(2*j + 1);
                end else begin
                    va = mid_val_q[off(s-1) + 2*j];
                    vb = mid_val_q[off(s-1) + 2*j + 1];
                    ia = mid_idx_q[off(s-1) + 2*j];
                    ib = mid_idx_q[off(s-1) + 2*j + 1];
                end
                if (take_hi(va, vb, src_mode[s])) begin
                    val_d[off(s) + j] = vb;
                    idx_d[off(s) + j] = ib;
                end else begin
                    val_d[off(s) + j] = va;
                    idx_d[off(s) + j] = ia;
                end
            end
        end
    end

    // Inner tree levels: payload loads only when the pipe advances with a valid beat upstream.
    always_ff @(posedge clk_in) begin
        if (adv) begin
            for (int s = 0; s < STAGES - 1; s++) begin
                if (src_vld[s]) begin
                    for (int j = 0; j < (LANES >> (s + 1)); j++) begin
                        mid_val_q[off(s) + j] <= val_d[off(s) + j];
                        mid_idx_q[off(s) + j] <= idx_d[off(s) + j];
                    end
                    mid_mode_q[s] <= src_mode[s];
                end
            end
        end
    end

    // Valid shift chain and the output level; bubbles move through as valid = 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_q      <= '0;
            out_val_q  <= '0;
            out_idx_q  <= '0;
            out_mode_q <= 1'b0;
        end else if (adv) begin
            vld_q <= src_vld;
            if (src_vld[STAGES-1]) begin
                out_val_q  <= val_d[NNODE-1];
                out_idx_q  <= idx_d[NNODE-1];
                out_mode_q <= src_mode[STAGES-1];
            end
        end
    end
endmodule

// File: tb/tb_comp_minmax_pipe.sv
// Bench for comp_minmax_pipe: an unsigned and a signed instance (LANES=4, D=8) share one
// stimulus stream; a queue-based reference model predicts every result.
module tb_comp_minmax_pipe;
    localparam int LANES  = 4;
    localparam int D      = 8;
    localparam int STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comp_minmax_pipe_if #(.LANES(LANES), .D(D)) ifu ();
    comp_minmax_pipe_if #(.LANES(LANES), .D(D)) ifs ();

    logic        vi  = 1'b0;
    logic        mi  = 1'b0;
    logic        ori = 1'b1;
    logic [31:0] di  = '0;

    assign ifu.in_valid  = vi;
    assign ifu.data_in   = di;
    assign ifu.mode_in   = mi;
    assign ifu.out_ready = ori;
    assign ifs.in_valid  = vi;
    assign ifs.data_in   = di;
    assign ifs.mode_in   = mi;
    assign ifs.out_ready = ori;

    comp_minmax_pipe #(.LANES(LANES), .D(D), .SIGNED(0)) u_uns (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifu)
    );

    comp_minmax_pipe #(.LANES(LANES), .D(D), .SIGNED(1)) u_sgn (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifs)
    );

    typedef struct {
        logic [31:0] data;
        logic        mode;
        int          acc;
    } beat_t;

    beat_t q[$];
    int    n_cmp      = 0;
    int    n_err      = 0;
    int    cyc        = 0;
    int    last_stall = -1;
    int    n_pop      = 0;
    bit    done       = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int cval(input logic [7:0] c, input bit sg);
        if (sg) return int'($signed(c));
        return int'({24'b0, c});
    endfunction

    // Linear scan: strictly better value replaces the current best, so the lowest lane wins ties.
    function automatic void ref_ext(input logic [31:0] d, input logic mx, input bit sg,
                                    output logic [7:0] v, output logic [1:0] ix);
        int best;
        int bi;
        best = cval(d[7:0], sg);
        bi   = 0;
        for (int k = 1; k < LANES; k++) begin
            int x;
            x = cval(d[k*8 +: 8], sg);
            if (mx ? (x > best) : (x < best)) begin
                best = x;
                bi   = k;
            end
        end
        v  = d[bi*8 +: 8];
        ix = 2'(bi);
    endfunction

    function automatic logic [31:0] rnd_beat();
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k*8 +: 8] = 8'h00;
                1:       r[k*8 +: 8] = 8'h7F;
                2:       r[k*8 +: 8] = 8'h80;
                3:       r[k*8 +: 8] = 8'hFF;
                default: r[k*8 +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: record accepted beats, check every visible result against the queue head.
    always @(negedge clk) begin : mon
        logic [7:0] ev;
        logic [1:0] ei;
        if (rst_n) begin
            chk("in_ready_u", 32'(ifu.in_ready), 32'(!ifu.out_valid || ori));
            chk("in_ready_s", 32'(ifs.in_ready), 32'(!ifs.out_valid || ori));
            if (vi && ifu.in_ready) q.push_back('{di, mi, cyc});
            if (ifu.out_valid) begin
                chk("out_has_beat", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    ref_ext(q[0].data, q[0].mode, 1'b0, ev, ei);
                    chk("u_data", 32'(ifu.data_out), 32'(ev));
                    chk("u_idx",  32'(ifu.idx_out),  32'(ei));
                    chk("u_mode", 32'(ifu.mode_out), 32'(q[0].mode));
                    ref_ext(q[0].data, q[0].mode, 1'b1, ev, ei);
                    chk("s_vld",  32'(ifs.out_valid), 32'd1);
                    chk("s_data", 32'(ifs.data_out), 32'(ev));
                    chk("s_idx",  32'(ifs.idx_out),  32'(ei));
                    chk("s_mode", 32'(ifs.mode_out), 32'(q[0].mode));
                    if (ori) begin
                        if (q[0].acc > last_stall) chk("latency", 32'(cyc - q[0].acc), STAGES);
                        void'(q.pop_front());
                        n_pop++;
                    end else begin
                        last_stall = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic m);
        int n = 0;
        vi = 1'b1;
        di = d;
        mi = m;
        do begin
            @(negedge clk);
            n++;
        end while (!ifu.in_ready && n < 200);
        chk("accept", 32'(ifu.in_ready), 32'd1);
        @(posedge clk);
        #1;
        vi = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] d, input logic m,
                           input logic [7:0] uv, input logic [1:0] ui,
                           input logic [7:0] sv, input logic [1:0] si);
        int n = 0;
        send(d, m);
        do begin
            @(negedge clk);
            n++;
        end while (!ifu.out_valid && n < 20);
        chk({tag, "_lat"},   32'(n), STAGES);
        chk({tag, "_udata"}, 32'(ifu.data_out), 32'(uv));
        chk({tag, "_uidx"},  32'(ifu.idx_out),  32'(ui));
        chk({tag, "_umode"}, 32'(ifu.mode_out), 32'(m));
        chk({tag, "_sdata"}, 32'(ifs.data_out), 32'(sv));
        chk({tag, "_sidx"},  32'(ifs.idx_out),  32'(si));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_uvld"},  32'(ifu.out_valid), 32'd0);
        chk({tag, "_udata"}, 32'(ifu.data_out),  32'd0);
        chk({tag, "_uidx"},  32'(ifu.idx_out),   32'd0);
        chk({tag, "_umode"}, 32'(ifu.mode_out),  32'd0);
        chk({tag, "_svld"},  32'(ifs.out_valid), 32'd0);
        chk({tag, "_sdata"}, 32'(ifs.data_out),  32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        chk("rst0_inrdy", 32'(ifu.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed beats: lanes 3..0 packed MSB first.
        run_one("t1_min",  32'h40058010, 1'b0, 8'h05, 2'd2, 8'h80, 2'd1);
        run_one("t2_max",  32'h40058010, 1'b1, 8'h80, 2'd1, 8'h40, 2'd3);
        run_one("t3_tie",  32'h22222222, 1'b0, 8'h22, 2'd0, 8'h22, 2'd0);
        run_one("t3_tmax", 32'hFF22FF22, 1'b1, 8'hFF, 2'd1, 8'h22, 2'd0);
        run_one("t4_min",  32'h7F8001FF, 1'b0, 8'h01, 2'd1, 8'h80, 2'd2);
        run_one("t4_max",  32'h7F8001FF, 1'b1, 8'hFF, 2'd0, 8'h7F, 2'd3);

        // Backpressure: six back-to-back beats with out_ready low for five cycles.
        base = n_pop;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rnd_beat(), 1'(i % 2));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                ori = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                ori = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(n_pop - base), 32'd6);

        // Reset with two beats in flight.
        send(32'h44332211, 1'b1);
        vi = 1'b1;
        di = 32'h01020304;
        mi = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        vi = 1'b0;
        chk("pre_rst_vld", 32'(ifu.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one("t6_post", 32'h10203040, 1'b0, 8'h10, 2'd3, 8'h10, 2'd3);

        // Randomized traffic with input gaps and random downstream stalls.
        base = n_pop;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rnd_beat(), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ori = ($urandom_range(0, 3) != 0);
                end
                ori = 1'b1;
            end
        join
        drain();
        chk("rnd_count", 32'(n_pop - base), 32'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
